// File: rtl/serial_chunk_adder_if.sv
// Operand/result bundle for serial_chunk_adder: start/busy/done handshake plus
// the operand and result buses.
interface serial_chunk_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle WIDTH-bit adder working CHUNK bits per clock through a full-adder chain.
// Define SERIAL_CHUNK_ADDER_SAT_EN to saturate sum on signed overflow.
module serial_chunk_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic                clk,
   input  logic                reset,
   serial_chunk_adder_if.slave bus
);
   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;

   logic [WIDTH-1:0] a_sh, b_sh, work, work_nx, sum_r, sum_nx;
   logic [CW-1:0]    cnt;
   logic             carry, cout_r, ovf_r;
   logic [CHUNK:0]   c;
   logic             last, load, busy, done, ovf_nx;

   // Full-adder chain over the low CHUNK bits; partial sum enters work from the MSB side
   always_comb begin
      c       = '0;
      c[0]    = carry;
      work_nx = work >> CHUNK;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         work_nx[WIDTH-CHUNK+i] = a_sh[i] ^ b_sh[i] ^ c[i];
         c[i+1] = (a_sh[i] & b_sh[i]) | (c[i] & (a_sh[i] ^ b_sh[i]));
      end
   end

   assign last   = (cnt == CW'(N - 1));
   assign ovf_nx = c[CHUNK-1] ^ c[CHUNK];

   always_comb begin
      sum_nx = work_nx;
`ifdef SERIAL_CHUNK_ADDER_SAT_EN
      // On the last chunk a_sh[CHUNK-1] still holds the original sign bit of a
      if (ovf_nx) begin
         sum_nx          = '0;
         sum_nx[WIDTH-1] = 1'b1;
         if (!a_sh[CHUNK-1])
            sum_nx = ~sum_nx;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load     = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last)
               state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (bus.start) begin
               load     = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sh   <= '0;
         b_sh   <= '0;
         work   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (load) begin
         a_sh  <= bus.a;
         b_sh  <= bus.b;
         carry <= bus.cin;
         work  <= '0;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sh  <= a_sh >> CHUNK;
         b_sh  <= b_sh >> CHUNK;
         carry <= c[CHUNK];
         work  <= work_nx;
         cnt   <= cnt + CW'(1);
         if (last) begin
            sum_r  <= sum_nx;
            cout_r <= c[CHUNK];
            ovf_r  <= ovf_nx;
         end
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.sum      = sum_r;
   assign bus.cout     = cout_r;
   assign bus.overflow = ovf_r;
endmodule

// File: doc/serial_chunk_adder.md
# serial_chunk_adder

Parametrised multi-cycle adder that sums two WIDTH-bit operands plus carry-in by processing CHUNK bits per clock through a chain of full-adder cells. It reports unsigned carry-out and signed overflow, and uses a start/busy/done handshake. It sits in the piano datapath wherever wide sums (note-frequency accumulation, volume/mix arithmetic) can trade latency for area. It is the sequential, width-generic successor to the single-bit full-adder cell.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock (full-adder cells in the chain); 1 ≤ CHUNK ≤ WIDTH.

Ports (N = WIDTH/CHUNK):
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is idle or done.
- a  input  WIDTH  operand A, captured on an accepted start.
- b  input  WIDTH  operand B, captured on an accepted start.
- cin  input  1  carry-in, captured on an accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; result outputs are updated in this cycle.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  unsigned carry out of the MSB.
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: capture a, b and cin into shift registers, clear the chunk counter, go to RUN. IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - Add the low CHUNK bits of both shift registers plus the carry register.
  - Shift the CHUNK-bit partial sum into the working result from the MSB side.
  - Shift both operand registers right by CHUNK.
  - Update the carry register and increment the counter.
  - Record the carry into the MSB on the last chunk.
- After chunk N-1: copy the working result to sum, set cout and overflow, go to DONE.
- DONE, start=1: capture new operands and go to RUN (back-to-back operation). DONE, start=0: go to IDLE.
- start in RUN is ignored; the operands and the operation in flight are unaffected.
- sum, cout and overflow change only on the completing edge; they are stable in every other cycle.
- Arithmetic is modulo 2^WIDTH. The mathematical result is {cout, sum} = a + b + cin, which is WIDTH+1 bits.

## Timing
- Reset (synchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, counter=0, carry=0.
- Reset asserted mid-RUN aborts the operation with no done pulse and returns all outputs to their reset values. Reset wins over a simultaneous start.
- start accepted at rising edge E0: busy=1 from E0.
- Chunk i is processed at edge E(i+1), for i = 0 … N-1.
- At edge EN the block registers the result, done=1 and busy=0 for exactly one cycle. Latency is N cycles from start acceptance to done.
- Back-to-back: a start accepted at the DONE edge gives busy=1 in the next cycle. Throughput is one result per N+1 cycles.
- CHUNK=WIDTH gives N=1: done is asserted one cycle after start.

## Configuration
- SERIAL_CHUNK_ADDER_SAT_EN defined:
  - When overflow=1, sum saturates: to 2^(WIDTH-1)-1 if a[WIDTH-1]=0, or to -2^(WIDTH-1) if a[WIDTH-1]=1.
  - cout and overflow still report the raw result.
- SERIAL_CHUNK_ADDER_SAT_EN undefined: sum is always the wrapped raw result.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- Basic add: a=0x1234, b=0x4321, cin=0, start one cycle -> done exactly 4 cycles after acceptance, sum=0x5555, cout=0, overflow=0, busy high for 4 cycles.
- Carry propagation and cin: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, overflow=0. Carry must ripple across all 4 chunks.
- Positive overflow: a=0x7FFF, b=0x0001, cin=0 -> overflow=1, cout=0. sum=0x8000 with SAT_EN off; sum=0x7FFF with SAT_EN on.
- Negative overflow: a=0x8000, b=0x8000, cin=0 -> cout=1, overflow=1. sum=0x0000 with SAT_EN off; sum=0x8000 with SAT_EN on.
- Handshake:
  - start held high through RUN with changing a/b -> only the first operands are used.
  - start during the DONE cycle with a=0x0001, b=0x0002 -> second done 4 cycles later with sum=0x0003; the first sum holds until then.
- Reset mid-operation: assert reset at the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0; no done pulse follows. A new start afterwards completes normally.
